// File: rtl/frame_serializer.sv
// Parallel-to-serial frame feeder: valid/ready input, one-entry skid hold,
// and gapless bit-serial output with frame boundary markers and a frame counter.
module frame_serializer #(
  parameter int unsigned FRAME_W   = 4,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               out_bit,
  output logic               out_valid,
  output logic               out_first,
  output logic               out_last,
  output logic               busy,
  output logic [CNT_W-1:0]   frame_cnt
);

  localparam int unsigned IDX_W = $clog2(FRAME_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state, state_n;
  logic [FRAME_W-1:0] shifter, shifter_n;
  logic [IDX_W-1:0]   bit_idx, bit_idx_n;
  logic [FRAME_W-1:0] hold, hold_n;
  logic               hold_full, hold_full_n;
  logic [CNT_W-1:0]   frame_cnt_n;
  logic               in_ready_n, out_valid_n, out_first_n, out_last_n, busy_n;
  logic               accept;

  // Shifter always drains from bit 0, so frames are reordered on load.
  function automatic logic [FRAME_W-1:0] send_order(input logic [FRAME_W-1:0] d);
    logic [FRAME_W-1:0] r;
    r = d;
    if (!LSB_FIRST) begin
      for (int i = 0; i < int'(FRAME_W); i++) r[i] = d[FRAME_W-1-i];
    end
    return r;
  endfunction

  assign accept  = in_valid & in_ready;
  assign out_bit = shifter[0];

  always_comb begin
    state_n     = state;
    shifter_n   = shifter;
    bit_idx_n   = bit_idx;
    hold_n      = hold;
    hold_full_n = hold_full;
    frame_cnt_n = frame_cnt;
    out_first_n = 1'b0;
    out_last_n  = 1'b0;

    case (state)
      IDLE: begin
        if (accept) begin
          state_n     = SHIFT;
          shifter_n   = send_order(in_data);
          bit_idx_n   = '0;
          out_first_n = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_idx == LAST_IDX) begin
          frame_cnt_n = frame_cnt + CNT_W'(1);
          bit_idx_n   = '0;
          if (hold_full) begin
            shifter_n   = send_order(hold);
            hold_full_n = 1'b0;
            out_first_n = 1'b1;
          end else if (accept) begin
            shifter_n   = send_order(in_data);
            out_first_n = 1'b1;
          end else begin
            state_n   = IDLE;
            shifter_n = '0;
          end
        end else begin
          shifter_n  = {1'b0, shifter[FRAME_W-1:1]};
          bit_idx_n  = bit_idx + IDX_W'(1);
          out_last_n = ((bit_idx + IDX_W'(1)) == LAST_IDX);
          if (accept) begin
            hold_n      = in_data;
            hold_full_n = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    in_ready_n  = ~hold_full_n;
    out_valid_n = (state_n == SHIFT);
    busy_n      = (state_n == SHIFT) | hold_full_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shifter   <= '0;
      bit_idx   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      frame_cnt <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      shifter   <= shifter_n;
      bit_idx   <= bit_idx_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      frame_cnt <= frame_cnt_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      out_first <= out_first_n;
      out_last  <= out_last_n;
      busy      <= busy_n;
    end
  end

endmodule

// File: tb/tb_frame_serializer.sv
// Directed bench for frame_serializer: default build, MSB-first build and
// a narrow-counter build share one clock and reset.
module tb_frame_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data  [3];
  logic       in_valid [3];
  logic       in_ready [3];
  logic       out_bit  [3];
  logic       out_valid[3];
  logic       out_first[3];
  logic       out_last [3];
  logic       busy     [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  logic [3:0] fr_q[$];
  logic [3:0] got_q[$];
  bit         rdy_q[$];
  int         gaps;
  int         nbits;

  always #5 clk = ~clk;

  frame_serializer #(.FRAME_W(4), .LSB_FIRST(1'b1), .CNT_W(8)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_bit(out_bit[0]), .out_valid(out_valid[0]),
    .out_first(out_first[0]), .out_last(out_last[0]), .busy(busy[0]),
    .frame_cnt(cnt0));

  frame_serializer #(.FRAME_W(4), .LSB_FIRST(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_bit(out_bit[1]), .out_valid(out_valid[1]),
    .out_first(out_first[1]), .out_last(out_last[1]), .busy(busy[1]),
    .frame_cnt(cnt1));

  frame_serializer #(.FRAME_W(4), .LSB_FIRST(1'b1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_data(in_data[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_bit(out_bit[2]), .out_valid(out_valid[2]),
    .out_first(out_first[2]), .out_last(out_last[2]), .busy(busy[2]),
    .frame_cnt(cnt2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) in_valid[i] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Feeds fr_q into DUT d with in_valid held while frames remain; rebuilds
  // received nibbles into got_q, counts idle cycles inside the stream.
  task automatic stream(input int d, input bit msb);
    int         fi;
    int         total;
    bit         started;
    logic [3:0] cur;
    int         p;
    fi = 0; nbits = 0; gaps = 0; started = 0; cur = '0;
    total = 4 * fr_q.size();
    got_q.delete();
    rdy_q.delete();
    for (int cyc = 0; cyc < 400 && nbits < total; cyc++) begin
      @(negedge clk);
      if (out_valid[d]) begin
        started = 1;
        p = nbits % 4;
        cur[msb ? 3 - p : p] = out_bit[d];
        nbits++;
        if (nbits % 4 == 0) got_q.push_back(cur);
      end else if (started) begin
        gaps++;
      end
      rdy_q.push_back(in_ready[d]);
      if (fi < fr_q.size()) begin
        in_valid[d] = 1'b1;
        in_data[d]  = fr_q[fi];
        if (in_ready[d]) fi++;
      end else begin
        in_valid[d] = 1'b0;
        in_data[d]  = 4'($urandom);
      end
    end
    chk("stream_bits", 32'(nbits), 32'(total));
    @(negedge clk);
  endtask

  logic [3:0] eb;
  logic [1:0] exp_cnt2 [5];
  int         toggles;

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = 1'b0;
      in_data[i]  = '0;
    end
    exp_cnt2 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready[0]),  32'h1);
    chk("rst_out_valid", 32'(out_valid[0]), 32'h0);
    chk("rst_out_bit",   32'(out_bit[0]),   32'h0);
    chk("rst_first",     32'(out_first[0]), 32'h0);
    chk("rst_last",      32'(out_last[0]),  32'h0);
    chk("rst_busy",      32'(busy[0]),      32'h0);
    chk("rst_cnt",       32'(cnt0),         32'h0);
    rst = 1'b0;

    // Single frame 0111, LSB first
    @(negedge clk);
    in_data[0] = 4'b0111; in_valid[0] = 1'b1;
    @(negedge clk);
    in_valid[0] = 1'b0; in_data[0] = 4'b1000;
    eb = 4'b0111;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk("t1_valid", 32'(out_valid[0]), 32'h1);
      chk("t1_bit",   32'(out_bit[0]),   32'(eb[k]));
      chk("t1_first", 32'(out_first[0]), 32'(k == 0));
      chk("t1_last",  32'(out_last[0]),  32'(k == 3));
    end
    @(negedge clk);
    chk("t1_valid_after", 32'(out_valid[0]), 32'h0);
    chk("t1_bit_after",   32'(out_bit[0]),   32'h0);
    chk("t1_busy_after",  32'(busy[0]),      32'h0);
    chk("t1_cnt",         32'(cnt0),         32'h1);

    // Sixteen back-to-back frames
    do_reset();
    fr_q.delete();
    for (int i = 0; i < 16; i++) fr_q.push_back(4'(i));
    stream(0, 1'b0);
    chk("t2_gaps", 32'(gaps), 32'h0);
    chk("t2_frames", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("t2_frame", 32'(got_q[i]), 32'(i));
    toggles = 0;
    for (int i = 1; i < rdy_q.size(); i++) if (rdy_q[i] != rdy_q[i-1]) toggles++;
    chk("t2_ready_toggles", 32'(toggles >= 8), 32'h1);
    chk("t2_cnt", 32'(cnt0), 32'd16);

    // A then 5,F presented back to back: 5 skids, F waits for A's last bit
    fr_q.delete();
    fr_q.push_back(4'hA); fr_q.push_back(4'h5); fr_q.push_back(4'hF);
    stream(0, 1'b0);
    chk("t3_gaps", 32'(gaps), 32'h0);
    chk("t3_frames", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      chk("t3_f0", 32'(got_q[0]), 32'hA);
      chk("t3_f1", 32'(got_q[1]), 32'h5);
      chk("t3_f2", 32'(got_q[2]), 32'hF);
    end
    if (rdy_q.size() >= 7) begin
      chk("t3_rdy0", 32'(rdy_q[0]), 32'h1);
      chk("t3_rdy1", 32'(rdy_q[1]), 32'h1);
      chk("t3_rdy2", 32'(rdy_q[2]), 32'h0);
      chk("t3_rdy3", 32'(rdy_q[3]), 32'h0);
      chk("t3_rdy4", 32'(rdy_q[4]), 32'h0);
      chk("t3_rdy5", 32'(rdy_q[5]), 32'h1);
      chk("t3_rdy6", 32'(rdy_q[6]), 32'h0);
    end
    chk("t3_cnt", 32'(cnt0), 32'd19);

    // Reset mid-frame with a held frame
    @(negedge clk);
    in_data[0] = 4'hC; in_valid[0] = 1'b1;
    @(negedge clk);
    in_data[0] = 4'h3;
    @(negedge clk);
    in_valid[0] = 1'b0;
    chk("t4_ready_held", 32'(in_ready[0]), 32'h0);
    @(negedge clk);
    chk("t4_bit2", 32'(out_bit[0]), 32'h1);
    rst = 1'b1;
    #1;
    chk("t4_valid", 32'(out_valid[0]), 32'h0);
    chk("t4_bit",   32'(out_bit[0]),   32'h0);
    chk("t4_ready", 32'(in_ready[0]),  32'h1);
    chk("t4_busy",  32'(busy[0]),      32'h0);
    chk("t4_last",  32'(out_last[0]),  32'h0);
    chk("t4_cnt",   32'(cnt0),         32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_idle_after", 32'(out_valid[0]), 32'h0);
    fr_q.delete();
    fr_q.push_back(4'h9);
    stream(0, 1'b0);
    chk("t4_frames", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) chk("t4_f9", 32'(got_q[0]), 32'h9);
    chk("t4_cnt_after", 32'(cnt0), 32'h1);

    // MSB-first build
    fr_q.delete();
    fr_q.push_back(4'b1011);
    stream(1, 1'b1);
    if (got_q.size() > 0) chk("t5_msb_first", 32'(got_q[0]), 32'hB);
    chk("t5_cnt", 32'(cnt1), 32'h1);

    // Narrow counter wraps
    for (int k = 0; k < 5; k++) begin
      fr_q.delete();
      fr_q.push_back(4'(k + 3));
      stream(2, 1'b0);
      chk("t6_cnt", 32'(cnt2), 32'(exp_cnt2[k]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
